// File: rtl/pe_feed_pkg.sv
// Shared types and widths for the PE chain operand feeder.
package pe_feed_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoadW,
        StStream,
        StDrain
    } feed_state_e;

    localparam int unsigned EXP_W      = 5;
    localparam int unsigned IMG_W      = 24;
    localparam int unsigned WGT_W      = 36;
    localparam int unsigned PSUM_W     = 16;
    localparam int unsigned TILE_CNT_W = 8;

endpackage

// File: rtl/pe_feeder.sv
// Launch-side driver for the SD4 MAC PE chain: weight-stationary tiles of image beats,
// followed by drain bubbles so in-flight psums clear the chain before the weight changes.
module pe_feeder
    import pe_feed_pkg::*;
#(
    parameter int unsigned TILE_LEN     = 9,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TILE_CNT_W-1:0] num_tiles,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [EXP_W-1:0]      w_exp_bias,
    input  logic [WGT_W-1:0]      w_data,
    input  logic [PSUM_W-1:0]     w_bias,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [IMG_W-1:0]      i_data,
    output logic [EXP_W-1:0]      exp_bias_out,
    output logic [IMG_W-1:0]      image_out,
    output logic [WGT_W-1:0]      weight_out,
    output logic [PSUM_W-1:0]     psum_out,
    output logic                  valid_out,
    output logic                  last_out,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BeatW  = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    feed_state_e             state_q, state_d;
    logic [TILE_CNT_W-1:0]   tiles_left_q, tiles_left_d;
    logic [BeatW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [DrainW-1:0]       drain_cnt_q, drain_cnt_d;
    logic [PSUM_W-1:0]       bias_hold_q, bias_hold_d;
    logic [WGT_W-1:0]        weight_q, weight_d;
    logic [EXP_W-1:0]        exp_bias_q, exp_bias_d;
    logic [IMG_W-1:0]        image_q, image_d;
    logic [PSUM_W-1:0]       psum_q, psum_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;

    logic beat_last;
    logic drain_last;

    assign beat_last  = (beat_cnt_q == BeatW'(TILE_LEN - 1));
    assign drain_last = (drain_cnt_q == DrainW'(DRAIN_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start && (num_tiles != '0)) state_d = StLoadW;
            StLoadW:  if (w_valid) state_d = StStream;
            StStream: if (i_valid && beat_last) state_d = StDrain;
            StDrain:  if (drain_last) state_d = (tiles_left_q != '0) ? StLoadW : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Beat outputs default to a bubble every cycle; weight side holds unless reloaded.
    always_comb begin
        tiles_left_d = tiles_left_q;
        beat_cnt_d   = beat_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        bias_hold_d  = bias_hold_q;
        weight_d     = weight_q;
        exp_bias_d   = exp_bias_q;
        image_d      = '0;
        psum_d       = '0;
        valid_d      = 1'b0;
        last_d       = 1'b0;
        done_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_tiles != '0) tiles_left_d = num_tiles;
                    else                 done_d       = 1'b1;
                end
            end
            StLoadW: begin
                if (w_valid) begin
                    weight_d    = w_data;
                    exp_bias_d  = w_exp_bias;
                    bias_hold_d = w_bias;
                    beat_cnt_d  = '0;
                end
            end
            StStream: begin
                if (i_valid) begin
                    image_d    = i_data;
                    psum_d     = bias_hold_q;
                    valid_d    = 1'b1;
                    last_d     = beat_last;
                    beat_cnt_d = beat_cnt_q + BeatW'(1);
                    if (beat_last) begin
                        drain_cnt_d  = '0;
                        tiles_left_d = tiles_left_q - TILE_CNT_W'(1);
                    end
                end
            end
            StDrain: begin
                drain_cnt_d = drain_cnt_q + DrainW'(1);
                if (drain_last && (tiles_left_q == '0)) done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tiles_left_q <= '0;
            beat_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            bias_hold_q  <= '0;
            weight_q     <= '0;
            exp_bias_q   <= '0;
            image_q      <= '0;
            psum_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            tiles_left_q <= tiles_left_d;
            beat_cnt_q   <= beat_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            bias_hold_q  <= bias_hold_d;
            weight_q     <= weight_d;
            exp_bias_q   <= exp_bias_d;
            image_q      <= image_d;
            psum_q       <= psum_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        w_ready      = (state_q == StLoadW);
        i_ready      = (state_q == StStream);
        busy         = (state_q != StIdle);
        done         = done_q;
        exp_bias_out = exp_bias_q;
        image_out    = image_q;
        weight_out   = weight_q;
        psum_out     = psum_q;
        valid_out    = valid_q;
        last_out     = last_q;
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder with TILE_LEN=3, DRAIN_CYCLES=4.
module tb_pe_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_tiles;
    logic        w_valid;
    logic        w_ready;
    logic [4:0]  w_exp_bias;
    logic [35:0] w_data;
    logic [15:0] w_bias;
    logic        i_valid;
    logic        i_ready;
    logic [23:0] i_data;
    logic [4:0]  exp_bias_out;
    logic [23:0] image_out;
    logic [35:0] weight_out;
    logic [15:0] psum_out;
    logic        valid_out;
    logic        last_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pe_feeder #(
        .TILE_LEN    (3),
        .DRAIN_CYCLES(4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_tiles   (num_tiles),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_exp_bias  (w_exp_bias),
        .w_data      (w_data),
        .w_bias      (w_bias),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_data      (i_data),
        .exp_bias_out(exp_bias_out),
        .image_out   (image_out),
        .weight_out  (weight_out),
        .psum_out    (psum_out),
        .valid_out   (valid_out),
        .last_out    (last_out),
        .busy        (busy),
        .done        (done)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a one-shot job and load one weight; leaves the DUT in STREAM.
    task automatic begin_job(input logic [7:0] nt, input logic [35:0] wd, input logic [15:0] wb,
                             input logic [4:0] we);
        start = 1'b1;
        num_tiles = nt;
        tick();
        start = 1'b0;
        w_valid = 1'b1;
        w_data = wd;
        w_bias = wb;
        w_exp_bias = we;
        tick();
        w_valid = 1'b0;
    endtask

    logic [4:0] pat;
    int         n;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_tiles = '0;
        w_valid = 1'b0;
        w_exp_bias = '0;
        w_data = '0;
        w_bias = '0;
        i_valid = 1'b0;
        i_data = '0;
        tick();
        check_val("rst_weight", 64'(weight_out), 64'd0);
        check_val("rst_image", 64'(image_out), 64'd0);
        check_val("rst_valid", 64'(valid_out), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_wready", 64'(w_ready), 64'd0);
        check_val("rst_iready", 64'(i_ready), 64'd0);
        rst = 1'b0;
        tick();

        // Basic single tile, back-to-back beats.
        start = 1'b1;
        num_tiles = 8'd1;
        tick();
        start = 1'b0;
        check_val("a_busy", 64'(busy), 64'd1);
        check_val("a_wready", 64'(w_ready), 64'd1);
        w_valid = 1'b1;
        w_data = 36'h123456789;
        w_bias = 16'h0010;
        w_exp_bias = 5'h07;
        tick();
        w_valid = 1'b0;
        check_val("a_weight", 64'(weight_out), 64'h123456789);
        check_val("a_exp", 64'(exp_bias_out), 64'h07);
        check_val("a_iready", 64'(i_ready), 64'd1);
        check_val("a_wready_off", 64'(w_ready), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            i_valid = 1'b1;
            i_data = 24'(i);
            tick();
            check_val("a_image", 64'(image_out), 64'(i));
            check_val("a_psum", 64'(psum_out), 64'h10);
            check_val("a_valid", 64'(valid_out), 64'd1);
            check_val("a_last", 64'(last_out), (i == 3) ? 64'd1 : 64'd0);
        end
        i_valid = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (!done) check_val("a_bubble", 64'(valid_out), 64'd0);
        end
        check_val("a_drain_len", 64'(n), 64'd4);
        check_val("a_busy_fall", 64'(busy), 64'd0);
        check_val("a_weight_hold", 64'(weight_out), 64'h123456789);
        tick();
        check_val("a_done_pulse", 64'(done), 64'd0);

        // Gapped image stream.
        begin_job(8'd1, 36'h000000042, 16'h0033, 5'h01);
        pat = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            i_valid = pat[i];
            i_data = 24'(32 + i);
            tick();
            check_val("b_valid", 64'(valid_out), 64'(pat[i]));
            check_val("b_image", 64'(image_out), pat[i] ? 64'(32 + i) : 64'd0);
            check_val("b_last", 64'(last_out), (i == 4) ? 64'd1 : 64'd0);
        end
        i_valid = 1'b0;
        repeat (3) tick();
        check_val("b_no_early_done", 64'(done), 64'd0);
        tick();
        check_val("b_done", 64'(done), 64'd1);

        // Two tiles, w_valid held high, stray start during STREAM.
        begin_job(8'd2, 36'h0FEDCBA98, 16'h0100, 5'h03);
        w_valid = 1'b1;
        w_data = 36'hABC;
        w_bias = 16'h0200;
        w_exp_bias = 5'h1C;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_data = 24'(7 + i);
            start = (i == 1);
            tick();
            check_val("c_weight_stream", 64'(weight_out), 64'h0FEDCBA98);
            check_val("c_psum1", 64'(psum_out), 64'h0100);
            check_val("c_last1", 64'(last_out), (i == 2) ? 64'd1 : 64'd0);
        end
        start = 1'b0;
        i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("c_weight_drain", 64'(weight_out), 64'h0FEDCBA98);
            check_val("c_drain_bubble", 64'(valid_out), 64'd0);
        end
        tick();
        check_val("c_weight_new", 64'(weight_out), 64'hABC);
        check_val("c_exp_new", 64'(exp_bias_out), 64'h1C);
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_data = 24'(4 + i);
            tick();
            check_val("c_psum2", 64'(psum_out), 64'h0200);
            check_val("c_image2", 64'(image_out), 64'(4 + i));
            check_val("c_last2", 64'(last_out), (i == 2) ? 64'd1 : 64'd0);
        end
        i_valid = 1'b0;
        repeat (3) tick();
        check_val("c_done_early", 64'(done), 64'd0);
        tick();
        check_val("c_done", 64'(done), 64'd1);
        check_val("c_busy_off", 64'(busy), 64'd0);
        tick();
        check_val("c_no_restart", 64'(busy), 64'd0);
        check_val("c_wready_idle", 64'(w_ready), 64'd0);
        check_val("c_done_once", 64'(done), 64'd0);
        w_valid = 1'b0;

        // Empty job.
        start = 1'b1;
        num_tiles = 8'd0;
        tick();
        start = 1'b0;
        check_val("d_done", 64'(done), 64'd1);
        check_val("d_busy", 64'(busy), 64'd0);
        check_val("d_wready", 64'(w_ready), 64'd0);
        tick();
        check_val("d_done_once", 64'(done), 64'd0);
        check_val("d_wready2", 64'(w_ready), 64'd0);

        // Reset in the middle of STREAM, then reset versus start.
        begin_job(8'd1, 36'h111111111, 16'h0044, 5'h05);
        i_valid = 1'b1;
        i_data = 24'h55;
        tick();
        check_val("e_beat", 64'(valid_out), 64'd1);
        rst = 1'b1;
        tick();
        check_val("e_image", 64'(image_out), 64'd0);
        check_val("e_valid", 64'(valid_out), 64'd0);
        check_val("e_weight", 64'(weight_out), 64'd0);
        check_val("e_psum", 64'(psum_out), 64'd0);
        check_val("e_exp", 64'(exp_bias_out), 64'd0);
        check_val("e_busy", 64'(busy), 64'd0);
        check_val("e_iready", 64'(i_ready), 64'd0);
        check_val("e_done", 64'(done), 64'd0);
        rst = 1'b0;
        i_valid = 1'b0;
        tick();
        check_val("e_done_after", 64'(done), 64'd0);
        check_val("e_busy_after", 64'(busy), 64'd0);
        rst = 1'b1;
        start = 1'b1;
        num_tiles = 8'd1;
        tick();
        check_val("e_rst_prio", 64'(busy), 64'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        check_val("e_rst_prio_wready", 64'(w_ready), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
